// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array feeder: FSM state encoding,
// default lane geometry and counter width.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_t;

  localparam int DEFAULT_BIT_WIDTH = 16;
  localparam int DEFAULT_N         = 4;
  localparam int LANE_W            = DEFAULT_BIT_WIDTH;
  localparam int CNT_W             = 16;

  // Bit offset of lane 'lane' inside a packed row of 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// Fixed-depth shift register used to delay one data lane by DEPTH cycles.
// Synchronous active-high reset flushes every stage to zero.
module skew_line #(
  parameter int bit_width = 16,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [bit_width-1:0] shift_data,
  output logic [bit_width-1:0] tap
);

  logic [bit_width-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= shift_data;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign tap = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Weight/data feeder for an N x N systolic array: loads N weight rows, then streams
// skewed data vectors, then drains the skew lines. Optional FEEDER_STALL_COUNT_EN adds stall_cnt.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int bit_width = DEFAULT_BIT_WIDTH,
  parameter int N         = DEFAULT_N
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_vec,
  input  logic                   wt_valid,
  output logic                   wt_ready,
  input  logic [N*bit_width-1:0] wt_in,
  input  logic                   dat_valid,
  output logic                   dat_ready,
  input  logic [N*bit_width-1:0] dat_in,
  output logic                   control,
  output logic [N*bit_width-1:0] wt_path_out,
  output logic [N*bit_width-1:0] data_out,
  output logic                   busy,
  output logic                   done,
  output feeder_state_t          fsm_state
`ifdef FEEDER_STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0]       stall_cnt
`endif
);

  // Handshake: a beat is valid && ready in the same cycle; ready depends on state only.

  localparam int BEAT_W       = $clog2(N + 1);
  localparam int DRAIN_CYCLES = 2 * N;
  localparam int DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  feeder_state_t state, state_next;

  logic [BEAT_W-1:0]  beat_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [CNT_W-1:0]   num_vec_q;
  logic [CNT_W-1:0]   vec_cnt;

  logic wt_beat, dat_beat;
  logic last_wt, last_vec, drain_last;

  assign wt_beat    = (state == LOAD) && wt_valid;
  assign dat_beat   = (state == STREAM) && dat_valid;
  assign last_wt    = wt_beat && (beat_cnt == BEAT_W'(N - 1));
  assign last_vec   = dat_beat && (vec_cnt == (num_vec_q - CNT_W'(1)));
  assign drain_last = (state == DRAIN) && (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));
  assign fsm_state  = state;

  always_comb begin
    state_next = state;
    wt_ready   = 1'b0;
    dat_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = LOAD;
      end
      LOAD: begin
        wt_ready = 1'b1;
        if (last_wt) state_next = (num_vec_q != '0) ? STREAM : DRAIN;
      end
      STREAM: begin
        dat_ready = 1'b1;
        if (last_vec) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_last) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      drain_cnt   <= '0;
      num_vec_q   <= '0;
      vec_cnt     <= '0;
      control     <= 1'b0;
      wt_path_out <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && start) num_vec_q <= num_vec;

      if (state == IDLE)  beat_cnt <= '0;
      else if (wt_beat)   beat_cnt <= beat_cnt + BEAT_W'(1);

      if (state == IDLE)  vec_cnt <= '0;
      else if (dat_beat)  vec_cnt <= vec_cnt + CNT_W'(1);

      if (state == DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
      else                drain_cnt <= '0;

      // The weight path is a one-cycle registered copy of each accepted row.
      control     <= wt_beat;
      wt_path_out <= wt_beat ? wt_in : '0;
    end
  end

  // Lane i is delayed 1+i cycles so the array sees a diagonal wavefront.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [bit_width-1:0] lane_feed;
    assign lane_feed = dat_beat ? dat_in[lane_lsb(i, bit_width) +: bit_width] : '0;

    skew_line #(
      .bit_width(bit_width),
      .DEPTH    (1 + i)
    ) u_skew (
      .clk       (clk),
      .reset     (reset),
      .shift_data(lane_feed),
      .tap       (data_out[lane_lsb(i, bit_width) +: bit_width])
    );
  end

`ifdef FEEDER_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= '0;
    end else if ((state == STREAM) && !dat_valid && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4, bit_width=16) with a data_out timeline scoreboard.
module tb_systolic_feeder;
  import systolic_pkg::*;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   num_vec = '0;
  logic          wt_valid = 1'b0;
  logic          wt_ready;
  logic [DW-1:0] wt_in = '0;
  logic          dat_valid = 1'b0;
  logic          dat_ready;
  logic [DW-1:0] dat_in = '0;
  logic          control;
  logic [DW-1:0] wt_path_out;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  feeder_state_t fsm_state;
`ifdef FEEDER_STALL_COUNT_EN
  logic [15:0]   stall_cnt;
`endif

  systolic_feeder #(.bit_width(W), .N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_vec    (num_vec),
    .wt_valid   (wt_valid),
    .wt_ready   (wt_ready),
    .wt_in      (wt_in),
    .dat_valid  (dat_valid),
    .dat_ready  (dat_ready),
    .dat_in     (dat_in),
    .control    (control),
    .wt_path_out(wt_path_out),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done),
    .fsm_state  (fsm_state)
`ifdef FEEDER_STALL_COUNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Scoreboard: entry k is the data_out value expected after the k-th upcoming edge.
  logic [DW-1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit beat, input logic [DW-1:0] vec);
    logic [DW-1:0] tmp;
    logic [DW-1:0] exp_v;
    while (exp_q.size() < N + 1) exp_q.push_back('0);
    if (beat) begin
      for (int i = 0; i < N; i++) begin
        tmp = exp_q[i];
        tmp[i*W +: W] = vec[i*W +: W];
        exp_q[i] = tmp;
      end
    end
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    chk("data_out", data_out, exp_v);
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = 16'($urandom_range(0, 65535));
    return v;
  endfunction

  // Driver: one complete job from start to done.
  task automatic run_job(input int nv, input int stall_start, input int stall_len,
                         input bit wt_bubble, input bit busy_start);
    logic [DW-1:0] row;
    logic [DW-1:0] vec;
    bit v;
    int acc, k, stalls;
    start   = 1'b1;
    num_vec = 16'(nv);
    tick(1'b0, '0);
    start = 1'b0;
    chk("busy_load", busy, 1);
    chk("wt_ready_load", wt_ready, 1);
    chk("dat_ready_load", dat_ready, 0);
    chk("control_pre", control, 0);
    for (int b = 0; b < N; b++) begin
      if (wt_bubble && b == 2) begin
        wt_valid = 1'b0;
        wt_in    = rand_vec();
        tick(1'b0, '0);
        chk("control_bubble", control, 0);
        chk("wt_path_bubble", wt_path_out, 0);
        chk("wt_ready_bubble", wt_ready, 1);
      end
      for (int i = 0; i < N; i++) row[i*W +: W] = 16'((b + 1) * 16 + i);
      wt_valid = 1'b1;
      wt_in    = row;
      tick(1'b0, '0);
      chk("control_beat", control, 1);
      chk("wt_path_beat", wt_path_out, row);
    end
    wt_valid = 1'b0;
    chk("wt_ready_after_load", wt_ready, 0);
    chk("dat_ready_after_load", dat_ready, (nv > 0) ? 1 : 0);
    acc = 0; k = 0; stalls = 0;
    while (acc < nv) begin
      v   = !(k >= stall_start && k < stall_start + stall_len);
      vec = (k == 0) ? {16'd40, 16'd30, 16'd20, 16'd10} : rand_vec();
      chk("dat_ready_stream", dat_ready, 1);
      if (busy_start && k == 1) begin
        start   = 1'b1;
        num_vec = 16'd7;
      end
      dat_valid = v;
      dat_in    = vec;
      tick(v, vec);
      start = 1'b0;
      chk("control_stream", control, 0);
      chk("wt_path_stream", wt_path_out, 0);
      if (v) acc++; else stalls++;
      k++;
    end
    dat_valid = 1'b1;
    for (int d = 0; d < 2 * N; d++) begin
      dat_in = rand_vec();
      chk("busy_drain", busy, 1);
      chk("dat_ready_drain", dat_ready, 0);
      chk("wt_ready_drain", wt_ready, 0);
      chk("done_drain", done, (d == 2 * N - 1) ? 1 : 0);
      tick(1'b0, '0);
    end
    dat_valid = 1'b0;
    chk("busy_end", busy, 0);
    chk("done_end", done, 0);
    chk("state_end", 64'(fsm_state), 64'(IDLE));
`ifdef FEEDER_STALL_COUNT_EN
    chk("stall_cnt", stall_cnt, 16'(stalls));
`endif
  endtask

  // Directed sequence
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_control", control, 0);
    chk("reset_wt_path", wt_path_out, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_wt_ready", wt_ready, 0);
    chk("reset_dat_ready", dat_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_state", 64'(fsm_state), 64'(IDLE));
    tick(1'b0, '0);

    // Two-vector job with back-to-back weight rows.
    run_job(2, 100, 0, 1'b0, 1'b0);
    // Stalls mid-stream, a weight bubble and a stray start while busy.
    run_job(6, 2, 3, 1'b1, 1'b1);
    // Zero-vector job goes straight from LOAD to DRAIN.
    run_job(0, 100, 0, 1'b0, 1'b0);

    // Reset in the middle of STREAM.
    start   = 1'b1;
    num_vec = 16'd5;
    tick(1'b0, '0);
    start    = 1'b0;
    wt_valid = 1'b1;
    for (int b = 0; b < N; b++) begin
      wt_in = rand_vec();
      tick(1'b0, '0);
    end
    wt_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dat_valid = 1'b1;
      dat_in    = rand_vec();
      tick(1'b1, dat_in);
    end
    reset     = 1'b1;
    start     = 1'b1;
    dat_valid = 1'b1;
    wt_valid  = 1'b1;
    exp_q.delete();
    tick(1'b0, '0);
    chk("midreset_control", control, 0);
    chk("midreset_wt_path", wt_path_out, 0);
    chk("midreset_wt_ready", wt_ready, 0);
    chk("midreset_dat_ready", dat_ready, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_state", 64'(fsm_state), 64'(IDLE));
    reset     = 1'b0;
    start     = 1'b0;
    dat_valid = 1'b0;
    wt_valid  = 1'b0;
    for (int k = 0; k < 2 * N + 2; k++) begin
      tick(1'b0, '0);
      chk("postreset_done", done, 0);
      chk("postreset_busy", busy, 0);
    end

    // Clean single-vector job after the reset.
    run_job(1, 100, 0, 1'b0, 1'b0);
    tick(1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
